// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: OV7670 bus IDs, responder state encoding and a
// small shift helper used by both the responder and the initiator.
package sccb_pkg;

    localparam logic [7:0] OV7670_WRITE_ID = 8'h42;
    localparam logic [7:0] OV7670_READ_ID  = 8'h43;

    // Bit counter reload value for an MSB-first byte.
    localparam logic [2:0] BitMsb = 3'd7;

    typedef enum logic [3:0] {
        StIdle,
        StId,
        StIdAck,
        StSub,
        StSubAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdNa,
        StWaitStop
    } sccb_state_e;

    // Append one sampled bit to an MSB-first shift register.
    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
        return {cur[6:0], bit_in};
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Two-flop synchronizer for the SIO_C/SIO_D pair plus a previous-sample flop,
// producing clock edges and START/STOP conditions in the local clock domain.
module sccb_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sio_c,
    input  logic sio_d,
    output logic c_level,
    output logic d_level,
    output logic c_rise,
    output logic c_fall,
    output logic start,
    output logic stop
);

    logic [1:0] c_sync_q;
    logic [1:0] d_sync_q;
    logic       c_prev_q;
    logic       d_prev_q;

    // Synchronize both lines; idle bus level is high, so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            c_prev_q <= 1'b1;
            d_prev_q <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[0], sio_c};
            d_sync_q <= {d_sync_q[0], sio_d};
            c_prev_q <= c_sync_q[1];
            d_prev_q <= d_sync_q[1];
        end
    end

    assign c_level = c_sync_q[1];
    assign d_level = d_sync_q[1];
    assign c_rise  = c_sync_q[1] & ~c_prev_q;
    assign c_fall  = ~c_sync_q[1] & c_prev_q;
    // C must be stable high across both samples so a skewed C edge is not a condition.
    assign start   = c_sync_q[1] & c_prev_q & d_prev_q & ~d_sync_q[1];
    assign stop    = c_sync_q[1] & c_prev_q & ~d_prev_q & d_sync_q[1];

endmodule

// File: rtl/sccb_responder.sv
// SCCB target endpoint (OV7670-style). Oversamples SIO_C/SIO_D, decodes
// 3-phase writes and 2-phase reads, strobes writes out to a register file
// and returns register contents on the bus.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DeviceAddress = OV7670_WRITE_ID,
    parameter bit         DriveAck      = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_sio_c,
    inout  wire        io_sio_d,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_data,
    output logic       o_wr_valid,
    input  logic [7:0] i_rd_data,
    output logic       o_busy
);

    logic c_level;
    logic d_level;
    logic c_rise;
    logic c_fall;
    logic start;
    logic stop;

    sccb_line_sync u_line_sync (
        .clk     (CLK),
        .rst_n   (RST),
        .sio_c   (i_sio_c),
        .sio_d   (io_sio_d),
        .c_level (c_level),
        .d_level (d_level),
        .c_rise  (c_rise),
        .c_fall  (c_fall),
        .start   (start),
        .stop    (stop)
    );

    sccb_state_e state_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        rd_mode_q;
    logic        drive_en_q;
    logic        drive_val_q;
    logic [7:0]  reg_addr_q;
    logic [7:0]  reg_data_q;
    logic        wr_valid_q;
    logic        busy_q;

    logic [7:0]  shifted;
    logic [7:0]  read_id;

    assign shifted = shift_in(shift_q, d_level);
    assign read_id = DeviceAddress | 8'h01;

    // Protocol FSM. In the ACK states bit_cnt_q distinguishes the first c_fall
    // (start driving the ACK) from the second (release and advance).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            bit_cnt_q   <= BitMsb;
            shift_q     <= 8'h00;
            rd_mode_q   <= 1'b0;
            drive_en_q  <= 1'b0;
            drive_val_q <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_data_q  <= 8'h00;
            wr_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            if (start) begin
                // Repeated START is legal and discards any partial byte.
                state_q     <= StId;
                bit_cnt_q   <= BitMsb;
                drive_en_q  <= 1'b0;
                drive_val_q <= 1'b0;
            end else if (stop) begin
                state_q     <= StIdle;
                drive_en_q  <= 1'b0;
                drive_val_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        drive_en_q <= 1'b0;
                    end

                    StId: begin
                        if (c_rise) begin
                            shift_q <= shifted;
                            if (bit_cnt_q == 3'd0) begin
                                bit_cnt_q <= 3'd1;
                                if (shifted == DeviceAddress) begin
                                    state_q   <= StIdAck;
                                    rd_mode_q <= 1'b0;
                                    busy_q    <= 1'b1;
                                end else if (shifted == read_id) begin
                                    state_q   <= StIdAck;
                                    rd_mode_q <= 1'b1;
                                    busy_q    <= 1'b1;
                                end else begin
                                    // Not addressed: stay silent until STOP.
                                    state_q <= StWaitStop;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 3'd1;
                            end
                        end
                    end

                    StSub: begin
                        if (c_rise) begin
                            shift_q <= shifted;
                            if (bit_cnt_q == 3'd0) begin
                                reg_addr_q <= shifted;
                                bit_cnt_q  <= 3'd1;
                                state_q    <= StSubAck;
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 3'd1;
                            end
                        end
                    end

                    StWdata: begin
                        if (c_rise) begin
                            shift_q <= shifted;
                            if (bit_cnt_q == 3'd0) begin
                                reg_data_q <= shifted;
                                wr_valid_q <= 1'b1;
                                bit_cnt_q  <= 3'd1;
                                state_q    <= StWdataAck;
                            end else begin
                                bit_cnt_q <= bit_cnt_q - 3'd1;
                            end
                        end
                    end

                    StIdAck, StSubAck, StWdataAck: begin
                        if (c_fall) begin
                            if (bit_cnt_q != 3'd0) begin
                                drive_en_q  <= DriveAck;
                                drive_val_q <= 1'b0;
                                bit_cnt_q   <= 3'd0;
                            end else begin
                                bit_cnt_q   <= BitMsb;
                                drive_en_q  <= 1'b0;
                                drive_val_q <= 1'b0;
                                if (state_q == StIdAck && rd_mode_q) begin
                                    // Read byte is captured here and its MSB driven at once.
                                    state_q     <= StRdata;
                                    shift_q     <= i_rd_data;
                                    drive_en_q  <= 1'b1;
                                    drive_val_q <= i_rd_data[7];
                                end else if (state_q == StIdAck) begin
                                    state_q <= StSub;
                                end else if (state_q == StSubAck) begin
                                    state_q <= StWdata;
                                end else begin
                                    // No auto-increment: later bytes are ignored.
                                    state_q <= StWaitStop;
                                end
                            end
                        end
                    end

                    StRdata: begin
                        if (c_rise && drive_val_q && !d_level) begin
                            // Someone else is pulling the line low: back off.
                            state_q     <= StWaitStop;
                            drive_en_q  <= 1'b0;
                            drive_val_q <= 1'b0;
                        end else if (c_fall) begin
                            if (bit_cnt_q == 3'd0) begin
                                drive_en_q  <= 1'b0;
                                drive_val_q <= 1'b0;
                                state_q     <= StRdNa;
                            end else begin
                                shift_q     <= {shift_q[6:0], 1'b0};
                                drive_val_q <= shift_q[6];
                                bit_cnt_q   <= bit_cnt_q - 3'd1;
                            end
                        end
                    end

                    StRdNa: begin
                        // The initiator's NA/ACK value is irrelevant.
                        if (c_rise) begin
                            state_q <= StWaitStop;
                        end
                    end

                    StWaitStop: begin
                        drive_en_q <= 1'b0;
                    end

                    default: begin
                        state_q    <= StIdle;
                        drive_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Push-pull drive only inside ACK and read-data slots; released otherwise.
    assign io_sio_d   = drive_en_q ? drive_val_q : 1'bz;

    assign o_reg_addr = reg_addr_q;
    assign o_reg_data = reg_data_q;
    assign o_wr_valid = wr_valid_q;
    assign o_busy     = busy_q;

    // c_level is available for bus-idle checks but not needed by this FSM.
    logic unused_c_level;
    assign unused_c_level = c_level;

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: an open-drain SCCB initiator drives
// frames, a pull-up resolves the bus, a scoreboard checks write strobes and a
// register-file model predicts read data.
module tb_sccb_responder;
    import sccb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sio_c;
    logic       d_low;
    wire        sio_d;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       wr_valid;
    logic [7:0] rd_data;
    logic       busy;

    always #5 clk = ~clk;

    assign sio_d = d_low ? 1'b0 : 1'bz;
    pullup (sio_d);

    sccb_responder dut (
        .CLK        (clk),
        .RST        (rst_n),
        .i_sio_c    (sio_c),
        .io_sio_d   (sio_d),
        .o_reg_addr (reg_addr),
        .o_reg_data (reg_data),
        .o_wr_valid (wr_valid),
        .i_rd_data  (rd_data),
        .o_busy     (busy)
    );

    // External register file (written by strobes) and the bench's own model of it.
    logic [7:0] rf     [256];
    logic [7:0] mdl_rf [256];
    logic [7:0] mdl_addr;
    logic [7:0] mdl_data;
    assign rd_data = rf[reg_addr];

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];
    wr_t got;

    int tests = 0;
    int fails = 0;
    int half  = 8;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One bit slot, entered just after C falls; val=1 means release.
    task automatic bit_slot(input logic val, output logic smp);
        d_low = 1'b0;
        tick(4);
        d_low = ~val;
        tick(half - 4);
        sio_c = 1'b1;
        tick(half / 2);
        smp = sio_d;
        tick(half - half / 2);
        sio_c = 1'b0;
    endtask

    task automatic start_cond();
        if (!sio_c) begin
            d_low = 1'b0;
            tick(half);
            sio_c = 1'b1;
        end
        tick(half / 2);
        d_low = 1'b1;
        tick(half);
        sio_c = 1'b0;
    endtask

    task automatic stop_cond();
        tick(4);
        d_low = 1'b1;
        tick(half - 4);
        sio_c = 1'b1;
        tick(half / 2);
        d_low = 1'b0;
        tick(half);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic ack_low, input string nm);
        logic s;
        for (int i = 7; i >= 0; i--) bit_slot(b[i], s);
        bit_slot(1'b1, s);
        chk(nm, {31'd0, s}, ack_low ? 32'd0 : 32'd1);
    endtask

    // Write frame of nbytes (1..3) bytes followed by STOP.
    task automatic do_write(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] dat,
                            input int nbytes);
        logic match;
        match = (id == OV7670_WRITE_ID);
        start_cond();
        send_byte(id, match, "id_ack");
        chk("busy_after_id", {31'd0, busy}, {31'd0, match});
        if (nbytes >= 2) begin
            send_byte(sub, match, "sub_ack");
            if (match) mdl_addr = sub;
        end
        if (nbytes >= 3) begin
            if (match) begin
                exp_q.push_back({sub, dat});
                mdl_rf[sub] = dat;
                mdl_data    = dat;
            end
            send_byte(dat, match, "wdata_ack");
        end
        stop_cond();
        chk("reg_addr_after_stop", {24'd0, reg_addr}, {24'd0, mdl_addr});
        chk("busy_after_stop", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_read();
        logic [7:0] b;
        logic [7:0] exp;
        logic       s;
        start_cond();
        send_byte(OV7670_READ_ID, 1'b1, "rd_id_ack");
        chk("busy_in_read", {31'd0, busy}, 32'd1);
        exp = mdl_rf[mdl_addr];
        for (int i = 7; i >= 0; i--) bit_slot(1'b1, b[i]);
        chk("read_byte", {24'd0, b}, {24'd0, exp});
        bit_slot(1'b1, s);
        chk("na_slot_released", {31'd0, s}, 32'd1);
        stop_cond();
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wr_strobe: got write %0h/%0h, expected none", reg_addr, reg_data);
                end else begin
                    got = exp_q.pop_front();
                    chk("wr_addr", {24'd0, reg_addr}, {24'd0, got.a});
                    chk("wr_data", {24'd0, reg_data}, {24'd0, got.d});
                    rf[reg_addr] = reg_data;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] id;
        logic [7:0] exp;
        logic       s;
        int         op;

        for (int i = 0; i < 256; i++) begin
            exp       = 8'($urandom);
            rf[i]     = exp;
            mdl_rf[i] = exp;
        end
        rf[8'h0A]     = 8'h76;
        mdl_rf[8'h0A] = 8'h76;
        mdl_addr = 8'h00;
        mdl_data = 8'h00;
        sio_c    = 1'b1;
        d_low    = 1'b0;
        rst_n    = 1'b0;
        tick(4);
        chk("rst_reg_addr", {24'd0, reg_addr}, 32'd0);
        chk("rst_reg_data", {24'd0, reg_data}, 32'd0);
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bus_released", {31'd0, sio_d}, 32'd1);
        rst_n = 1'b1;
        tick(4);

        // Basic 3-phase write.
        half = 8;
        do_write(8'h42, 8'h12, 8'h80, 3);

        // Wrong ID: silent frame, no strobe, not busy.
        do_write(8'h60, 8'h12, 8'h80, 3);

        // 2-phase write sets the address, then read it back.
        do_write(8'h42, 8'h0A, 8'h00, 2);
        do_read();

        // Repeated START after 4 data bits of phase 3 aborts that write.
        start_cond();
        send_byte(8'h42, 1'b1, "rs_id_ack");
        send_byte(8'h33, 1'b1, "rs_sub_ack");
        mdl_addr = 8'h33;
        for (int i = 0; i < 4; i++) bit_slot(1'b0, s);
        chk("rs_reg_data_kept", {24'd0, reg_data}, {24'd0, mdl_data});
        start_cond();
        send_byte(8'h42, 1'b1, "rs2_id_ack");
        send_byte(8'h05, 1'b1, "rs2_sub_ack");
        mdl_addr = 8'h05;
        exp_q.push_back({8'h05, 8'h3C});
        mdl_rf[8'h05] = 8'h3C;
        mdl_data = 8'h3C;
        send_byte(8'h3C, 1'b1, "rs2_wdata_ack");
        stop_cond();

        // Reset while the responder drives read bit 3.
        do_write(8'h42, 8'h0A, 8'h00, 2);
        exp = mdl_rf[mdl_addr];
        start_cond();
        send_byte(OV7670_READ_ID, 1'b1, "rst_rd_id_ack");
        for (int i = 7; i >= 4; i--) begin
            bit_slot(1'b1, s);
            chk("rst_rd_bit", {31'd0, s}, {31'd0, exp[i]});
        end
        d_low = 1'b0;
        tick(half);
        sio_c = 1'b1;
        tick(half / 2);
        chk("rst_rd_bit3", {31'd0, sio_d}, {31'd0, exp[3]});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus", {31'd0, sio_d}, 32'd1);
        chk("rst_mid_addr", {24'd0, reg_addr}, 32'd0);
        chk("rst_mid_data", {24'd0, reg_data}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_wr_valid", {31'd0, wr_valid}, 32'd0);
        mdl_addr = 8'h00;
        mdl_data = 8'h00;
        tick(4);
        rst_n = 1'b1;
        tick(2 * half);
        do_write(8'h42, 8'h21, 8'h9B, 3);
        do_read();

        // Back-to-back writes at minimum half-period.
        half = 8;
        for (int n = 0; n < 5; n++) do_write(8'h42, 8'($urandom), 8'($urandom), 3);
        do_read();

        // Random mix of frame types and bus speeds.
        for (int n = 0; n < 14; n++) begin
            half = int'($urandom_range(8, 12));
            op   = int'($urandom_range(0, 3));
            case (op)
                0: do_write(8'h42, 8'($urandom), 8'($urandom), 3);
                1: do_write(8'h42, 8'($urandom), 8'h00, 2);
                2: do_read();
                default: begin
                    do id = 8'($urandom); while (id[7:1] == 7'h21);
                    do_write(id, 8'($urandom), 8'($urandom), 3);
                end
            endcase
        end

        tick(20);
        chk("pending_writes", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
